// File: rtl/fetch_pkg.sv
// Shared types and default widths for the instruction fetch unit.
package fetch_pkg;

    localparam int unsigned FETCH_ADDR_W         = 5;
    localparam int unsigned FETCH_INSTR_W        = 32;
    localparam int unsigned FETCH_TIMEOUT_CYCLES = 15;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        REQ   = 3'd1,
        WAIT  = 3'd2,
        HOLD  = 3'd3,
        DRAIN = 3'd4
    } fetch_state_t;

endpackage

// File: rtl/fetch_timeout_counter.sv
// Counts cycles spent waiting on a memory response; flags the last allowed cycle.
module fetch_timeout_counter #(
    parameter int unsigned TIMEOUT_CYCLES = 15
) (
    input  logic clk,
    input  logic resetN,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // High during the TIMEOUT_CYCLES-th waiting cycle (count starts at 0 on entry).
    assign expired_o = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    // Clear on entry, otherwise count up and saturate at the expiry value.
    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (enable_i && !expired_o) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Single-outstanding fetch engine between the PC and a req/gnt/rvalid instruction memory.
module instruction_fetch_unit
    import fetch_pkg::*;
#(
    parameter int unsigned ADDR_W         = FETCH_ADDR_W,
    parameter int unsigned INSTR_W        = FETCH_INSTR_W,
    parameter int unsigned TIMEOUT_CYCLES = FETCH_TIMEOUT_CYCLES
) (
    input  logic               clk,
    input  logic               resetN,
    input  logic [ADDR_W-1:0]  pcAddress,
    input  logic               flush,
    input  logic               halt,
    output logic               memReq,
    output logic [ADDR_W-1:0]  memAddr,
    input  logic               memGnt,
    input  logic               memRvalid,
    input  logic [INSTR_W-1:0] memRdata,
    output logic               instrValid,
    output logic [INSTR_W-1:0] instruction,
    input  logic               instrReady,
    output logic               pcAdvance,
    output logic               fetchError
);

    fetch_state_t        state_q, state_d;
    logic                mem_req_q, mem_req_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic                instr_valid_q, instr_valid_d;
    logic [INSTR_W-1:0]  instr_q, instr_d;
    logic                fetch_error_q, fetch_error_d;
    logic                drop_q, drop_d;
    logic                cnt_clear_c;
    logic                cnt_en_c;
    logic                cnt_expired;

    fetch_timeout_counter #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk      (clk),
        .resetN   (resetN),
        .clear_i  (cnt_clear_c),
        .enable_i (cnt_en_c),
        .expired_o(cnt_expired)
    );

    // Next-state and datapath decisions for one fetch at a time.
    always_comb begin
        state_d       = state_q;
        mem_req_d     = mem_req_q;
        mem_addr_d    = mem_addr_q;
        instr_valid_d = instr_valid_q;
        instr_d       = instr_q;
        fetch_error_d = fetch_error_q;
        drop_d        = drop_q;

        unique case (state_q)
            IDLE: begin
                if (!halt && !fetch_error_q) begin
                    mem_addr_d = pcAddress;
                    mem_req_d  = 1'b1;
                    state_d    = REQ;
                end
            end
            REQ: begin
                if (memGnt) begin
                    mem_req_d = 1'b0;
                    drop_d    = 1'b0;
                    state_d   = (flush || drop_q) ? DRAIN : WAIT;
                end else if (flush) begin
                    drop_d = 1'b1;
                end
            end
            WAIT: begin
                if (memRvalid) begin
                    if (!flush) begin
                        instr_d       = memRdata;
                        instr_valid_d = 1'b1;
                        state_d       = HOLD;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (flush) begin
                    state_d = DRAIN;
                end else if (cnt_expired) begin
                    fetch_error_d = 1'b1;
                    state_d       = IDLE;
                end
            end
            DRAIN: begin
                if (memRvalid) begin
                    state_d = IDLE;
                end else if (cnt_expired) begin
                    fetch_error_d = 1'b1;
                    state_d       = IDLE;
                end
            end
            HOLD: begin
                // A flush drops the held instruction even if decode is ready.
                if (flush || instrReady) begin
                    instr_valid_d = 1'b0;
                    state_d       = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        cnt_en_c    = (state_q == WAIT) || (state_q == DRAIN);
        cnt_clear_c = ((state_d == WAIT) || (state_d == DRAIN)) && (state_d != state_q);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q       <= IDLE;
            mem_req_q     <= 1'b0;
            mem_addr_q    <= '0;
            instr_valid_q <= 1'b0;
            instr_q       <= '0;
            fetch_error_q <= 1'b0;
            drop_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            mem_req_q     <= mem_req_d;
            mem_addr_q    <= mem_addr_d;
            instr_valid_q <= instr_valid_d;
            instr_q       <= instr_d;
            fetch_error_q <= fetch_error_d;
            drop_q        <= drop_d;
        end
    end

    // PC advances in the same cycle decode accepts the instruction.
    assign pcAdvance   = instr_valid_q && instrReady && !flush;

    assign memReq      = mem_req_q;
    assign memAddr     = mem_addr_q;
    assign instrValid  = instr_valid_q;
    assign instruction = instr_q;
    assign fetchError  = fetch_error_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench: TB-owned PC and memory, scoreboard of the instruction expected at the current PC.
module tb_instruction_fetch_unit;

    localparam int unsigned AW = 5;
    localparam int unsigned IW = 32;
    localparam int unsigned TO = 15;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          resetN, flush, halt, memGnt, memRvalid, instrReady;
    logic [AW-1:0] pcAddress, memAddr;
    logic [IW-1:0] memRdata, instruction;
    logic          memReq, instrValid, pcAdvance, fetchError;

    instruction_fetch_unit #(.ADDR_W(AW), .INSTR_W(IW), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .resetN(resetN), .pcAddress(pcAddress), .flush(flush), .halt(halt),
        .memReq(memReq), .memAddr(memAddr), .memGnt(memGnt), .memRvalid(memRvalid),
        .memRdata(memRdata), .instrValid(instrValid), .instruction(instruction),
        .instrReady(instrReady), .pcAdvance(pcAdvance), .fetchError(fetchError)
    );

    int total = 0;
    int bad   = 0;

    logic [IW-1:0] mem [0:31];
    logic [IW-1:0] exp_q [$];

    // memory model and stimulus knobs
    bit            mbusy = 1'b0;
    int unsigned   mlat = 0;
    logic [AW-1:0] maddr = '0;
    bit            mem_mute = 1'b0;
    int unsigned   gnt_pct = 100, rdy_pct = 100, flush_pct = 0, min_lat = 0, max_lat = 0;
    bit            flush_now = 1'b0;
    logic [AW-1:0] flush_tgt = '0;
    bit            mon_en = 1'b0;
    int            adv_cnt = 0;
    int            hs_cnt = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // The only instruction decode may accept next is the one at the current PC.
    task automatic sb_reset();
        exp_q.delete();
        exp_q.push_back(mem[pcAddress]);
    endtask

    // One clock of decode, memory and PC behaviour.
    task automatic cycle();
        bit            hs, g, rv;
        logic [AW-1:0] ga, tgt;
        @(negedge clk);
        memGnt    = 1'b0;
        memRvalid = 1'b0;
        memRdata  = IW'($urandom);
        if (mbusy) begin
            if (mlat == 0) begin
                if (!mem_mute) begin
                    memRvalid = 1'b1;
                    memRdata  = mem[maddr];
                end
            end else begin
                mlat--;
            end
        end else if (memReq && ($urandom_range(99) < gnt_pct)) begin
            memGnt = 1'b1;
        end
        instrReady = ($urandom_range(99) < rdy_pct);
        tgt   = AW'($urandom);
        flush = 1'b0;
        if (flush_now) begin
            flush     = 1'b1;
            tgt       = flush_tgt;
            flush_now = 1'b0;
        end else if ((memReq || mbusy || instrValid) && ($urandom_range(99) < flush_pct)) begin
            flush = 1'b1;
        end
        hs = instrValid && instrReady && !flush;
        g  = memGnt;
        rv = memRvalid;
        ga = memAddr;
        @(posedge clk);
        #1;
        if (g) begin
            mbusy = 1'b1;
            maddr = ga;
            mlat  = $urandom_range(max_lat, min_lat);
        end
        if (rv) mbusy = 1'b0;
        if (flush) begin
            pcAddress = tgt;
            sb_reset();
        end else if (hs) begin
            pcAddress = pcAddress + AW'(1);
            exp_q.push_back(mem[pcAddress]);
            hs_cnt++;
        end
    endtask

    // Monitor: protocol rules plus scoreboard pop on every accepted instruction.
    logic          p_req = 1'b0, p_gnt = 1'b0, p_val = 1'b0, p_rdy = 1'b0, p_flush = 1'b0, p_halt = 1'b0;
    logic [AW-1:0] p_addr = '0, p_pc = '0;
    logic [IW-1:0] p_instr = '0;
    logic          m_hs;
    logic [IW-1:0] m_exp;

    always begin
        @(negedge clk);
        #2;
        if (mon_en) begin
            m_hs = instrValid && instrReady && !flush;
            check("pcAdvance", 64'(pcAdvance), 64'(m_hs));
            if (pcAdvance) adv_cnt++;
            if (m_hs) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL scoreboard: got 0x%0h, required no accept pending", instruction);
                end else begin
                    m_exp = exp_q.pop_front();
                    check("instruction", 64'(instruction), 64'(m_exp));
                end
            end
            if (instrValid) check("no_req_in_hold", 64'(memReq), 64'(0));
            if (p_req && !p_gnt) begin
                check("req_held", 64'(memReq), 64'(1));
                check("req_addr_held", 64'(memAddr), 64'(p_addr));
            end
            if (p_val && !p_rdy && !p_flush)
                check("instr_held", 64'({instrValid, instruction}), 64'({1'b1, p_instr}));
            if (memReq && !p_req) begin
                check("req_not_halted", 64'(p_halt), 64'(0));
                check("req_addr", 64'(memAddr), 64'(p_pc));
            end
        end
        p_req   = memReq;
        p_gnt   = memGnt;
        p_val   = instrValid;
        p_rdy   = instrReady;
        p_flush = flush;
        p_halt  = halt;
        p_addr  = memAddr;
        p_pc    = pcAddress;
        p_instr = instruction;
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_memReq"}, 64'(memReq), 64'(0));
        check({tag, "_memAddr"}, 64'(memAddr), 64'(0));
        check({tag, "_instrValid"}, 64'(instrValid), 64'(0));
        check({tag, "_instruction"}, 64'(instruction), 64'(0));
        check({tag, "_pcAdvance"}, 64'(pcAdvance), 64'(0));
        check({tag, "_fetchError"}, 64'(fetchError), 64'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, required finish before 200000");
        $fatal(1, "watchdog");
    end

    initial begin
        int          a0, h0;
        logic [31:0] r;
        for (int i = 0; i < 32; i++) begin
            r      = $urandom;
            mem[i] = {r[IW-1:AW], AW'(i)};
        end
        mem[3] = 32'h2008_0005;
        mem[5] = 32'hDEAD_BEEF;
        resetN = 1'b0; flush = 1'b0; halt = 1'b0; memGnt = 1'b0; memRvalid = 1'b0;
        memRdata = '0; instrReady = 1'b0; pcAddress = 5'd3;

        #12;
        check_reset_outputs("reset");
        @(negedge clk);
        resetN = 1'b1;
        sb_reset();
        mon_en = 1'b1;

        // basic fetch: gnt in REQ, rvalid two cycles later, decode ready
        min_lat = 1; max_lat = 1;
        a0 = adv_cnt;
        repeat (5) cycle();
        check("basic_adv_count", 64'(adv_cnt - a0), 64'(1));
        check("basic_next_req", 64'(memReq), 64'(1));
        check("basic_next_addr", 64'(memAddr), 64'(4));

        // backpressure: five cycles of instrReady=0 in HOLD
        min_lat = 0; max_lat = 0; rdy_pct = 0;
        a0 = adv_cnt;
        cycle();
        cycle();
        repeat (5) begin
            cycle();
            check("bp_valid", 64'(instrValid), 64'(1));
            check("bp_instr", 64'(instruction), 64'(mem[4]));
        end
        check("bp_no_adv", 64'(adv_cnt - a0), 64'(0));
        rdy_pct = 100;
        cycle();
        check("bp_adv", 64'(adv_cnt - a0), 64'(1));

        // flush one cycle after gnt, stale DEAD_BEEF response arrives in DRAIN
        min_lat = 2; max_lat = 2;
        cycle();
        cycle();
        check("fw_granted", 64'(mbusy), 64'(1));
        flush_now = 1'b1; flush_tgt = 5'd12;
        repeat (4) begin
            cycle();
            check("fw_no_valid", 64'(instrValid), 64'(0));
        end
        check("fw_next_req", 64'(memReq), 64'(1));
        check("fw_next_addr", 64'(memAddr), 64'(12));

        // flush in REQ while gnt is held low for three cycles
        a0 = adv_cnt;
        gnt_pct = 0;
        flush_now = 1'b1; flush_tgt = 5'd20;
        repeat (3) begin
            cycle();
            check("fr_req_stable", 64'(memReq), 64'(1));
            check("fr_addr_stable", 64'(memAddr), 64'(12));
        end
        gnt_pct = 100; min_lat = 0; max_lat = 0;
        repeat (3) begin
            cycle();
            check("fr_no_valid", 64'(instrValid), 64'(0));
        end
        check("fr_no_adv", 64'(adv_cnt - a0), 64'(0));
        check("fr_next_addr", 64'({memReq, memAddr}), 64'({1'b1, 5'd20}));

        // halt while idle
        repeat (3) cycle();
        halt = 1'b1;
        repeat (4) begin
            cycle();
            check("halt_no_req", 64'(memReq), 64'(0));
        end
        halt = 1'b0;
        cycle();
        check("halt_resume", 64'({memReq, memAddr}), 64'({1'b1, 5'd21}));

        // timeout: grant, then silence
        mem_mute = 1'b1;
        cycle();
        for (int k = 1; k <= 15; k++) begin
            cycle();
            check($sformatf("timeout_wait%0d", k), 64'(fetchError), 64'(k == 15));
        end
        repeat (3) begin
            cycle();
            check("err_no_req", 64'(memReq), 64'(0));
            check("err_sticky", 64'(fetchError), 64'(1));
        end

        // asynchronous reset between clock edges; stale response then lands after reset
        #2;
        mon_en = 1'b0;
        resetN = 1'b0;
        #1;
        check_reset_outputs("async_reset");
        mem_mute = 1'b0;
        @(negedge clk);
        resetN = 1'b1;
        sb_reset();
        mon_en = 1'b1;
        h0 = hs_cnt;
        repeat (4) cycle();
        check("post_reset_fetch", 64'(hs_cnt - h0), 64'(1));
        check("post_reset_no_err", 64'(fetchError), 64'(0));

        // randomized traffic
        gnt_pct = 60; rdy_pct = 60; flush_pct = 8; min_lat = 0; max_lat = 5;
        h0 = hs_cnt;
        for (int i = 0; i < 3000; i++) begin
            cycle();
            if (halt) begin
                if ($urandom_range(99) < 20) halt = 1'b0;
            end else if ($urandom_range(99) < 3) begin
                halt = 1'b1;
            end
        end
        halt = 1'b0; flush_pct = 0; gnt_pct = 100; rdy_pct = 100;
        repeat (20) cycle();
        check("random_no_err", 64'(fetchError), 64'(0));
        check("random_progress", 64'((hs_cnt - h0) > 100), 64'(1));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/instruction_fetch_unit.md
Name: instruction_fetch_unit

Overview:
- Fetch engine that sits between the program counter and a variable-latency instruction memory.
- Takes the PC's current instruction address and issues one memory request at a time (req/gnt, then rvalid).
- Holds the returned instruction under a valid/ready handshake toward decode.
- Drives the PC's advance-enable when decode consumes an instruction; handles branch flush and halt.

Parameters:
ADDR_W, 5, instruction address width (matches PC width)
INSTR_W, 32, instruction width
TIMEOUT_CYCLES, 15, max cycles spent in WAIT/DRAIN before a fetch error is raised

Ports:
clk  input  1  system clock, rising edge
resetN  input  1  asynchronous active-low reset
pcAddress  input  ADDR_W  current instruction address from program counter
flush  input  1  taken branch/jump (PC loads target this edge); discards the fetch in flight
halt  input  1  stop issuing new fetches
memReq  output  1  memory request valid
memAddr  output  ADDR_W  request address, stable while memReq=1
memGnt  input  1  memory accepts request (memReq && memGnt = handshake)
memRvalid  input  1  read data valid, one cycle pulse
memRdata  input  INSTR_W  read data
instrValid  output  1  instruction available to decode
instruction  output  INSTR_W  fetched instruction
instrReady  input  1  decode consumes instruction
pcAdvance  output  1  enable to program counter: advance to next sequential address
fetchError  output  1  sticky error: memory response timed out

Behaviour:
- Async reset (resetN=0): state IDLE; memReq=0, memAddr=0, instrValid=0, instruction=0, pcAdvance=0, fetchError=0, timeout counter=0. Reset mid-transaction abandons it; a late memRvalid after reset is ignored (arrives in IDLE).
- States: IDLE, REQ, WAIT, HOLD, DRAIN.
- IDLE: if !halt && !fetchError, latch memAddr<=pcAddress and go to REQ. Otherwise stay. flush in IDLE has no effect. memRvalid in IDLE is ignored.
- REQ: memReq=1; memAddr is held constant; the request is never retracted.
  - On memGnt: go to WAIT if !flush, else DRAIN.
  - flush without gnt: set an internal drop flag; on gnt go to DRAIN.
- WAIT: counter increments each cycle.
  - memRvalid && !flush: instruction<=memRdata, instrValid<=1, go to HOLD.
  - memRvalid && flush: discard data, go to IDLE.
  - flush without rvalid: go to DRAIN.
  - Counter reaching TIMEOUT_CYCLES without rvalid: fetchError<=1, go to IDLE.
- DRAIN: counter continues.
  - memRvalid: discard data, go to IDLE.
  - Timeout: fetchError<=1, go to IDLE.
- HOLD: instrValid=1; instruction is stable until consumed.
  - pcAdvance = instrValid && instrReady && !flush (combinational).
  - Handshake: instrValid<=0, go to IDLE. The PC updates at the same edge, so IDLE samples the new address.
  - flush in HOLD: instrValid<=0, pcAdvance=0, go to IDLE regardless of instrReady.
  - halt does not drop a held instruction.
- Counter clears on every entry to WAIT/DRAIN. Width is $clog2(TIMEOUT_CYCLES+1).
- Memory protocol: rvalid never arrives in the same cycle as gnt. An rvalid arriving in REQ is ignored.
- Best-case throughput: one instruction per 4 cycles (IDLE, REQ+gnt, WAIT+rvalid, HOLD+ready).
- fetchError stays 1 until reset; the unit remains in IDLE.

Decomposition:
- Package fetch_pkg:
  - fetch_state_t enum {IDLE, REQ, WAIT, HOLD, DRAIN}
  - default width constants (ADDR_W=5, INSTR_W=32)
- One natural sub-module, fetch_timeout_counter: clear/enable inputs, expired output, parameterised by TIMEOUT_CYCLES.
- The FSM and datapath registers stay in instruction_fetch_unit.

Test Plan:
- Basic fetch:
  - Stimulus: pcAddress=5'd3, gnt in REQ cycle, rvalid 2 cycles later with memRdata=32'h2008_0005, instrReady=1.
  - Required: memAddr=3 during REQ; instrValid=1 with instruction=32'h2008_0005; pcAdvance pulses exactly 1 cycle; next request uses pcAddress=4.
- Backpressure:
  - Stimulus: instrReady=0 for 5 cycles in HOLD.
  - Required: instrValid and instruction stable; pcAdvance=0; memReq=0 throughout; advance on the first cycle instrReady=1.
- Flush in WAIT:
  - Stimulus: flush 1 cycle after gnt; rvalid 3 cycles later with 32'hDEAD_BEEF; PC now 5'd12.
  - Required: DEAD_BEEF never presented (instrValid stays 0); next memAddr=12.
- Flush in REQ before gnt:
  - Stimulus: hold gnt low 3 cycles, then gnt.
  - Required: memReq and memAddr stable until gnt; response dropped; pcAdvance never asserts for it.
- Timeout:
  - Stimulus: gnt, then no rvalid for 15 cycles.
  - Required: fetchError=1 after the 15th WAIT cycle; memReq stays 0 afterwards. resetN pulse low clears fetchError and all outputs asynchronously, without a clock edge.
- Halt:
  - Stimulus: halt=1 while in IDLE.
  - Required: no memReq while halt=1; the fetch resumes from the current pcAddress the cycle after halt drops.
